// File: rtl/adc_sample_deserializer.sv
// Serial ADC frame master: drives CS/SCLK and captures one DATA_W-bit sample per sample period.
// Optional macro ADC_OFFSET_BIN_CONV_EN: convert offset-binary captures to sign-extended two's complement.
module adc_sample_deserializer #(
  parameter int DATA_W        = 16,
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 100
) (
  input  logic        avl_clk_i,
  input  logic        avl_reset_n_i,
  input  logic        enable_i,
  input  logic        adc_sdata_i,
  output logic        adc_sclk_o,
  output logic        adc_cs_n_o,
  output logic [15:0] sample_o,
  output logic        sample_valid_o,
  output logic        busy_o
);

  // state | meaning
  // IDLE  | CS high, waiting for enable_i
  // SETUP | CS low, SCLK low for CLK_DIV cycles before the first bit
  // SHIFT | DATA_W SCLK periods, data captured on each SCLK rise
  // DONE  | CS high, sample published with a one-cycle valid pulse
  // WAIT  | CS high until the sample period has elapsed

  localparam int MIN_PERIOD = CLK_DIV * (2 * DATA_W + 1) + 2;
  localparam int EFF_PERIOD = (SAMPLE_PERIOD > MIN_PERIOD) ? SAMPLE_PERIOD : MIN_PERIOD;
  localparam int PER_W      = $clog2(EFF_PERIOD);
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W      = $clog2(DATA_W);

  localparam logic [PER_W-1:0] PER_LAST = PER_W'(EFF_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t              state_q;
  logic [PER_W-1:0]    per_cnt_q;
  logic [DIV_W-1:0]    div_cnt_q;
  logic [BIT_W-1:0]    bit_cnt_q;
  logic [DATA_W-1:0]   shift_q;
  logic                sclk_q;
  logic                cs_n_q;
  logic [15:0]         sample_q;
  logic                sample_valid_q;
  logic                busy_q;

  logic [DATA_W-1:0]   conv_word_d;
  logic [15:0]         sample_d;

  always_comb begin
    conv_word_d = shift_q;
`ifdef ADC_OFFSET_BIN_CONV_EN
    // Flipping the MSB of an offset-binary code yields the two's complement code.
    conv_word_d[DATA_W-1] = ~shift_q[DATA_W-1];
    sample_d = 16'($signed(conv_word_d));
`else
    sample_d = 16'(conv_word_d);
`endif
  end

  always_ff @(posedge avl_clk_i or negedge avl_reset_n_i) begin
    if (!avl_reset_n_i) begin
      state_q        <= S_IDLE;
      per_cnt_q      <= '0;
      div_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      sclk_q         <= 1'b0;
      cs_n_q         <= 1'b1;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable_i) begin
            state_q   <= S_SETUP;
            cs_n_q    <= 1'b0;
            busy_q    <= 1'b1;
            per_cnt_q <= '0;
            div_cnt_q <= DIV_LOAD;
          end
        end

        S_SETUP: begin
          per_cnt_q <= per_cnt_q + PER_W'(1);
          if (div_cnt_q == '0) begin
            state_q   <= S_SHIFT;
            div_cnt_q <= DIV_LOAD;
            bit_cnt_q <= BIT_LOAD;
          end else begin
            div_cnt_q <= div_cnt_q - DIV_W'(1);
          end
        end

        S_SHIFT: begin
          per_cnt_q <= per_cnt_q + PER_W'(1);
          if (div_cnt_q == '0) begin
            div_cnt_q <= DIV_LOAD;
            if (!sclk_q) begin
              sclk_q  <= 1'b1;
              shift_q <= {shift_q[DATA_W-2:0], adc_sdata_i};
            end else begin
              sclk_q <= 1'b0;
              if (bit_cnt_q == '0) begin
                state_q        <= S_DONE;
                cs_n_q         <= 1'b1;
                sample_q       <= sample_d;
                sample_valid_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q - BIT_W'(1);
              end
            end
          end else begin
            div_cnt_q <= div_cnt_q - DIV_W'(1);
          end
        end

        S_DONE: begin
          per_cnt_q <= per_cnt_q + PER_W'(1);
          busy_q    <= 1'b0;
          state_q   <= enable_i ? S_WAIT : S_IDLE;
        end

        S_WAIT: begin
          if (per_cnt_q == PER_LAST) begin
            if (enable_i) begin
              state_q   <= S_SETUP;
              cs_n_q    <= 1'b0;
              busy_q    <= 1'b1;
              per_cnt_q <= '0;
              div_cnt_q <= DIV_LOAD;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            per_cnt_q <= per_cnt_q + PER_W'(1);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign adc_sclk_o     = sclk_q;
  assign adc_cs_n_o     = cs_n_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = sample_valid_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_adc_sample_deserializer.sv
// Bench for adc_sample_deserializer: three parameterisations, each fed by a behavioural ADC model.
module tb_adc_sample_deserializer;

  localparam int ND = 3;
  localparam int DW0 = 16, CD0 = 2, SP0 = 80;
  localparam int DW1 = 16, CD1 = 2, SP1 = 10;
  localparam int DW2 = 12, CD2 = 1, SP2 = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [ND-1:0] rst_n, en, sdata, sclk, csn, valid, busy;
  logic [15:0]   sample [ND];

  adc_sample_deserializer #(.DATA_W(DW0), .CLK_DIV(CD0), .SAMPLE_PERIOD(SP0)) u_dut0 (
    .avl_clk_i(clk), .avl_reset_n_i(rst_n[0]), .enable_i(en[0]), .adc_sdata_i(sdata[0]),
    .adc_sclk_o(sclk[0]), .adc_cs_n_o(csn[0]), .sample_o(sample[0]),
    .sample_valid_o(valid[0]), .busy_o(busy[0]));

  adc_sample_deserializer #(.DATA_W(DW1), .CLK_DIV(CD1), .SAMPLE_PERIOD(SP1)) u_dut1 (
    .avl_clk_i(clk), .avl_reset_n_i(rst_n[1]), .enable_i(en[1]), .adc_sdata_i(sdata[1]),
    .adc_sclk_o(sclk[1]), .adc_cs_n_o(csn[1]), .sample_o(sample[1]),
    .sample_valid_o(valid[1]), .busy_o(busy[1]));

  adc_sample_deserializer #(.DATA_W(DW2), .CLK_DIV(CD2), .SAMPLE_PERIOD(SP2)) u_dut2 (
    .avl_clk_i(clk), .avl_reset_n_i(rst_n[2]), .enable_i(en[2]), .adc_sdata_i(sdata[2]),
    .adc_sclk_o(sclk[2]), .adc_cs_n_o(csn[2]), .sample_o(sample[2]),
    .sample_valid_o(valid[2]), .busy_o(busy[2]));

  int dw_a [ND] = '{DW0, DW1, DW2};
  int cd_a [ND] = '{CD0, CD1, CD2};
  int sp_a [ND] = '{SP0, SP1, SP2};

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic        prev_cs [ND];
  logic        prev_sclk [ND];
  int          fall_cnt [ND], last_fall [ND], prev_fall [ND];
  int          valid_cnt [ND], last_valid [ND];
  int          edges [ND], rises [ND], adc_falls [ND];
  int          edges_at_valid [ND], rises_at_valid [ND];
  int          hi_run [ND], min_gap [ND];
  logic [15:0] word [ND];
  logic [15:0] cur_word [ND];

  always @(posedge clk) cyc++;

  // Behavioural ADC plus event recorder, evaluated away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (prev_cs[d] && !csn[d]) begin
        prev_fall[d] = last_fall[d];
        last_fall[d] = cyc;
        fall_cnt[d]++;
        if (fall_cnt[d] > 1 && hi_run[d] < min_gap[d]) min_gap[d] = hi_run[d];
        edges[d] = 0;
        rises[d] = 0;
        adc_falls[d] = 0;
        cur_word[d] = word[d];
      end
      if (csn[d]) hi_run[d]++;
      else hi_run[d] = 0;
      if (sclk[d] != prev_sclk[d]) begin
        edges[d]++;
        if (sclk[d]) rises[d]++;
        else adc_falls[d]++;
      end
      if (valid[d]) begin
        valid_cnt[d]++;
        last_valid[d] = cyc;
        edges_at_valid[d] = edges[d];
        rises_at_valid[d] = rises[d];
      end
      sdata[d] = (adc_falls[d] < dw_a[d]) ? cur_word[d][dw_a[d]-1-adc_falls[d]] : 1'b0;
      prev_cs[d] = csn[d];
      prev_sclk[d] = sclk[d];
    end
  end

  // Reference: ADC code of width w as an unsigned number, optionally re-centred around zero.
  function automatic int model(input logic [15:0] raw, input int w);
    int v;
    v = int'(raw) % (1 << w);
`ifdef ADC_OFFSET_BIN_CONV_EN
    v = v - (1 << (w - 1));
`endif
    return int'(v & 32'hFFFF);
  endfunction

  function automatic int latency(input int d);
    return cd_a[d] * (1 + 2 * dw_a[d]);
  endfunction

  function automatic int eff_period(input int d);
    int mn;
    mn = cd_a[d] * (2 * dw_a[d] + 1) + 2;
    return (sp_a[d] > mn) ? sp_a[d] : mn;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_fall(input int d, input int budget);
    int start;
    bit ok;
    start = fall_cnt[d];
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #1;
      if (fall_cnt[d] != start) ok = 1'b1;
    end
    chk($sformatf("cs_fall_timeout_d%0d", d), int'(ok), 1);
  endtask

  task automatic wait_valid(input int d, input int budget);
    int start;
    bit ok;
    start = valid_cnt[d];
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #1;
      if (valid_cnt[d] != start) ok = 1'b1;
    end
    chk($sformatf("valid_timeout_d%0d", d), int'(ok), 1);
  endtask

  initial begin
    int e, fc, vc, exp_s;
    logic [15:0] w;
    logic [15:0] dir_words [3];
    dir_words[0] = 16'h0000;
    dir_words[1] = 16'hFFFF;
    dir_words[2] = 16'h1234;

    for (int d = 0; d < ND; d++) begin
      prev_cs[d] = 1'b1; prev_sclk[d] = 1'b0;
      fall_cnt[d] = 0; last_fall[d] = 0; prev_fall[d] = 0;
      valid_cnt[d] = 0; last_valid[d] = 0;
      edges[d] = 0; rises[d] = 0; adc_falls[d] = 0;
      edges_at_valid[d] = 0; rises_at_valid[d] = 0;
      hi_run[d] = 0; min_gap[d] = 1000;
      word[d] = 16'h0; cur_word[d] = 16'h0;
    end
    rst_n = '0;
    en = '0;
    step(3);

    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_cs_n_d%0d", d), int'(csn[d]), 1);
      chk($sformatf("rst_sclk_d%0d", d), int'(sclk[d]), 0);
      chk($sformatf("rst_sample_d%0d", d), int'(sample[d]), 0);
      chk($sformatf("rst_valid_d%0d", d), int'(valid[d]), 0);
      chk($sformatf("rst_busy_d%0d", d), int'(busy[d]), 0);
    end
    rst_n = '1;
    step(2);

    // First frame on the 16-bit / div-2 / period-80 instance, started from IDLE.
    word[0] = 16'hA5C3;
    e = cyc;
    en[0] = 1'b1;
    wait_fall(0, 10);
    chk("idle_start_delay", last_fall[0] - e, 1);
    wait_valid(0, 200);
    chk("latency_a5c3", last_valid[0] - last_fall[0], latency(0));
    chk("sample_a5c3", int'(sample[0]), model(16'hA5C3, DW0));
    chk("edges_a5c3", edges_at_valid[0], 2 * DW0);

    for (int k = 0; k < 8; k++) begin
      w = (k < 3) ? dir_words[k] : 16'($urandom);
      word[0] = w;
      wait_valid(0, 200);
      chk($sformatf("sample_d0_k%0d", k), int'(sample[0]), model(w, DW0));
      chk($sformatf("period_d0_k%0d", k), last_fall[0] - prev_fall[0], eff_period(0));
      chk($sformatf("latency_d0_k%0d", k), last_valid[0] - last_fall[0], latency(0));
    end
    exp_s = int'(sample[0]);
    step(5);
    chk("sample_hold", int'(sample[0]), exp_s);

    // Drop enable during bit 5; the frame must still complete.
    w = 16'($urandom);
    word[0] = w;
    wait_fall(0, 200);
    while (cyc < last_fall[0] + CD0 + 2 * CD0 * 5 + 1) step(1);
    en[0] = 1'b0;
    wait_valid(0, 200);
    chk("drop_sample", int'(sample[0]), model(w, DW0));
    fc = fall_cnt[0];
    step(200);
    chk("drop_no_new_frame", fall_cnt[0], fc);
    chk("drop_idle_busy", int'(busy[0]), 0);
    chk("drop_idle_cs", int'(csn[0]), 1);

    w = 16'($urandom);
    word[0] = w;
    e = cyc;
    en[0] = 1'b1;
    wait_fall(0, 10);
    chk("reenable_delay", last_fall[0] - e, 1);
    wait_valid(0, 200);
    chk("reenable_sample", int'(sample[0]), model(w, DW0));

    // Asynchronous reset during bit 8.
    wait_fall(0, 200);
    while (cyc < last_fall[0] + CD0 + 2 * CD0 * 8 + 1) step(1);
    vc = valid_cnt[0];
    #2;
    rst_n[0] = 1'b0;
    #1;
    chk("rst_mid_cs_n", int'(csn[0]), 1);
    chk("rst_mid_sclk", int'(sclk[0]), 0);
    chk("rst_mid_sample", int'(sample[0]), 0);
    chk("rst_mid_busy", int'(busy[0]), 0);
    en[0] = 1'b0;
    step(3);
    rst_n[0] = 1'b1;
    fc = fall_cnt[0];
    step(40);
    chk("rst_no_valid", valid_cnt[0], vc);
    chk("rst_no_frame", fall_cnt[0], fc);
    chk("rst_sample_zero", int'(sample[0]), 0);
    w = 16'($urandom);
    word[0] = w;
    e = cyc;
    en[0] = 1'b1;
    wait_fall(0, 10);
    chk("rst_restart_delay", last_fall[0] - e, 1);
    wait_valid(0, 200);
    chk("rst_restart_sample", int'(sample[0]), model(w, DW0));
    en[0] = 1'b0;

    // Period below the frame minimum: back-to-back frames at the minimum spacing.
    word[1] = 16'($urandom);
    en[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      w = word[1];
      wait_valid(1, 200);
      chk($sformatf("sample_d1_k%0d", k), int'(sample[1]), model(w, DW1));
      chk($sformatf("edges_d1_k%0d", k), edges_at_valid[1], 2 * DW1);
      if (k > 0) chk($sformatf("period_d1_k%0d", k), last_fall[1] - prev_fall[1], eff_period(1));
      word[1] = 16'($urandom);
    end
    wait_fall(1, 200);
    chk("gap_d1_min2", int'(min_gap[1] >= 2), 1);
    en[1] = 1'b0;

    // 12-bit capture.
    word[2] = 16'h0ABC;
    en[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = word[2];
      wait_valid(2, 200);
      chk($sformatf("sample_d2_k%0d", k), int'(sample[2]), model(w, DW2));
      chk($sformatf("rises_d2_k%0d", k), rises_at_valid[2], DW2);
      chk($sformatf("latency_d2_k%0d", k), last_valid[2] - last_fall[2], latency(2));
      if (k > 0) chk($sformatf("period_d2_k%0d", k), last_fall[2] - prev_fall[2], eff_period(2));
      word[2] = 16'($urandom);
    end
    en[2] = 1'b0;
    step(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
